// File: rtl/io_cond_pkg.sv
// Shared constants and helpers for the board input conditioning path.
//   CLK_HZ        system clock frequency feeding the Nios and the conditioner
//   DEBOUNCE_MS   default debounce window in milliseconds
//   KEY_RELEASED  idle level of an active-low board key
//   SWITCH_RESET  level a switch channel assumes while reset is held
//   ms_to_cycles  converts a millisecond window into clock cycles
//   cnt_width     width of a counter that can hold 0..cycles
package io_cond_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 1;

  localparam logic KEY_RELEASED = 1'b1;
  localparam logic SWITCH_RESET = 1'b0;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bundle of raw board pins and their conditioned counterparts.
//   button_raw          raw KEY pins, active-low, asynchronous
//   switch_raw          raw SW pins, asynchronous
//   button_clean        debounced key level, still active-low
//   switch_clean        debounced switch level
//   button_press_pulse  one-cycle strobe when a key is accepted as pressed
//   switch_change_pulse one-cycle strobe when a switch is accepted as toggled
// master: the board / pin side that drives raw levels.
// slave:  the conditioner that consumes raw levels and returns clean ones.
interface input_conditioner_if #(
  parameter int unsigned NUM_BUTTONS  = 4,
  parameter int unsigned NUM_SWITCHES = 10
);

  logic [NUM_BUTTONS-1:0]  button_raw;
  logic [NUM_SWITCHES-1:0] switch_raw;
  logic [NUM_BUTTONS-1:0]  button_clean;
  logic [NUM_SWITCHES-1:0] switch_clean;
  logic [NUM_BUTTONS-1:0]  button_press_pulse;
  logic [NUM_SWITCHES-1:0] switch_change_pulse;

  modport master (
    output button_raw,
    output switch_raw,
    input  button_clean,
    input  switch_clean,
    input  button_press_pulse,
    input  switch_change_pulse
  );

  modport slave (
    input  button_raw,
    input  switch_raw,
    output button_clean,
    output switch_clean,
    output button_press_pulse,
    output switch_change_pulse
  );

endinterface

// File: rtl/debounce_bit.sv
// Single-channel synchroniser + counter debouncer.
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   raw            asynchronous input pin
//   clean          accepted (debounced) level
//   rise           one-cycle strobe on the edge clean is committed 0->1
//   fall           one-cycle strobe on the edge clean is committed 1->0
// The synchronised level must differ from the accepted level for
// DEBOUNCE_CYCLES consecutive clocks before it is accepted; any return to the
// accepted level restarts the count. A held change on raw shows up on clean
// exactly 2 + DEBOUNCE_CYCLES edges later.
module debounce_bit
  import io_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter logic        RESET_LEVEL     = KEY_RELEASED
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // Next-state: qualify the synchronised level against the accepted one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q == stable_q) begin
      // Input agrees with the accepted level (or bounced back): restart.
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      // Held long enough: accept and strobe on the same edge.
      stable_d = sync2_q;
      cnt_d    = '0;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q  <= RESET_LEVEL;
      sync2_q  <= RESET_LEVEL;
      stable_q <= RESET_LEVEL;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign clean = stable_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw board KEY/SW pins before they reach the Nios PIO inputs.
//   clk_clk        system clock (same as the Nios clk_clk)
//   reset_reset_n  asynchronous active-low reset
//   bus            input_conditioner_if slave:
//                    button_raw / switch_raw          raw asynchronous pins
//                    button_clean / switch_clean      debounced levels
//                    button_press_pulse               key accepted as pressed
//                    switch_change_pulse              switch accepted as toggled
// Every bit is an independent debounce_bit. Keys stay active-low on the clean
// side so software reads of the button PIO are unchanged; releasing a key
// updates button_clean but raises no pulse.
module input_conditioner
  import io_cond_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned NUM_SWITCHES    = 10,
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS)
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input_conditioner_if.slave    bus
);

  // A key release is deliberately not reported, so its strobe is dropped.
  logic [NUM_BUTTONS-1:0]  btn_rise_unused;
  logic [NUM_SWITCHES-1:0] sw_rise;
  logic [NUM_SWITCHES-1:0] sw_fall;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_button
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (KEY_RELEASED)
    ) u_debounce (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .raw           (bus.button_raw[i]),
      .clean         (bus.button_clean[i]),
      .rise          (btn_rise_unused[i]),
      .fall          (bus.button_press_pulse[i])
    );
  end

  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_switch
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (SWITCH_RESET)
    ) u_debounce (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .raw           (bus.switch_raw[i]),
      .clean         (bus.switch_clean[i]),
      .rise          (sw_rise[i]),
      .fall          (sw_fall[i])
    );
  end

  // rise and fall are mutually exclusive flop outputs, so the OR is glitch-free.
  assign bus.switch_change_pulse = sw_rise | sw_fall;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with an 8-cycle debounce window.
// Combined 14-bit vectors are {button[3:0], switch[9:0]}.
module tb_input_conditioner;

  localparam int unsigned NB = 4;
  localparam int unsigned NS = 10;
  localparam int unsigned D  = 8;
  localparam logic [13:0] RstVec = {4'hF, 10'h000};

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  input_conditioner_if #(.NUM_BUTTONS(NB), .NUM_SWITCHES(NS)) bus ();

  input_conditioner #(
    .NUM_BUTTONS     (NB),
    .NUM_SWITCHES    (NS),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a bit is accepted once the last D synchronised samples
  // all disagree with its accepted level. Synchronisation is a 2-sample delay.
  logic [13:0] m_s1, m_s2, m_clean, m_pulse;
  logic [13:0] m_win[$];

  function automatic void model_reset();
    m_s1    = RstVec;
    m_s2    = RstVec;
    m_clean = RstVec;
    m_pulse = '0;
    m_win.delete();
  endfunction

  function automatic void model_edge();
    logic [13:0] raw;
    logic [13:0] w;
    bit          all_diff;
    raw = {bus.button_raw, bus.switch_raw};
    m_win.push_back(m_s2);
    if (m_win.size() > D) void'(m_win.pop_front());
    m_pulse = '0;
    if (m_win.size() == D) begin
      for (int b = 0; b < 14; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < int'(D); j++) begin
          w = m_win[j];
          if (w[b] == m_clean[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_clean[b] = ~m_clean[b];
          m_pulse[b] = (b >= 10) ? ~m_clean[b] : 1'b1;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model button_clean", 32'(bus.button_clean), 32'(m_clean[13:10]));
    check("model switch_clean", 32'(bus.switch_clean), 32'(m_clean[9:0]));
    check("model button_press_pulse", 32'(bus.button_press_pulse), 32'(m_pulse[13:10]));
    check("model switch_change_pulse", 32'(bus.switch_change_pulse), 32'(m_pulse[9:0]));
  endtask

  // One active edge: model follows the DUT, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  function automatic logic [13:0] cur_clean();
    return {bus.button_clean, bus.switch_clean};
  endfunction

  function automatic logic [13:0] cur_pulse();
    return {bus.button_press_pulse, bus.switch_change_pulse};
  endfunction

  // Count edges until bit idx of clean reaches target; check latency and strobe.
  task automatic measure(input string name, input int idx, input logic target,
                         input int exp_edges, input logic [13:0] exp_pulse);
    int          n;
    bit          hit;
    logic [13:0] cur;
    logic [13:0] p;
    n   = 0;
    hit = 1'b0;
    p   = '0;
    while (!hit && n < 20) begin
      tick();
      n++;
      cur = cur_clean();
      p   = cur_pulse();
      if (cur[idx] == target) hit = 1'b1;
      else check({name, " early pulse"}, 32'(p), 32'h0);
    end
    check({name, " latency"}, 32'(n), 32'(exp_edges));
    check({name, " pulse"}, 32'(p), 32'(exp_pulse));
    tick();
    check({name, " pulse width"}, 32'(cur_pulse()), 32'h0);
  endtask

  task automatic settle(input logic [3:0] b, input logic [9:0] s);
    bus.button_raw = b;
    bus.switch_raw = s;
    repeat (12) tick();
  endtask

  typedef struct {
    logic [3:0] b;
    logic [9:0] s;
    logic [3:0] exp_b;
    logic [9:0] exp_s;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [13:0] cur;
    checks = 0;
    errors = 0;
    vecs[0] = '{4'hF, 10'h000, 4'hF, 10'h000};
    vecs[1] = '{4'hE, 10'h155, 4'hE, 10'h155};
    vecs[2] = '{4'h5, 10'h2AA, 4'h5, 10'h2AA};
    vecs[3] = '{4'hA, 10'h3FF, 4'hA, 10'h3FF};
    vecs[4] = '{4'h0, 10'h001, 4'h0, 10'h001};
    vecs[5] = '{4'hF, 10'h000, 4'hF, 10'h000};

    rst_n          = 1'b1;
    bus.button_raw = 4'hF;
    bus.switch_raw = '0;
    model_reset();
    #3 rst_n = 1'b0;
    #1;
    check("initial reset button_clean", 32'(bus.button_clean), 32'hF);
    check("initial reset switch_clean", 32'(bus.switch_clean), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) tick();

    // 1: reset mid-run, on the very cycle the strobes are high, no clock edge.
    bus.button_raw = 4'h0;
    bus.switch_raw = 10'h3FF;
    repeat (10) tick();
    check("t1 pre-reset press pulse", 32'(bus.button_press_pulse), 32'hF);
    check("t1 pre-reset switch_clean", 32'(bus.switch_clean), 32'h3FF);
    #2 rst_n = 1'b0;
    #1;
    check("t1 reset button_clean", 32'(bus.button_clean), 32'hF);
    check("t1 reset switch_clean", 32'(bus.switch_clean), 32'h0);
    check("t1 reset press pulse", 32'(bus.button_press_pulse), 32'h0);
    check("t1 reset change pulse", 32'(bus.switch_change_pulse), 32'h0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Table of settled levels.
    for (int i = 0; i < 6; i++) begin
      settle(vecs[i].b, vecs[i].s);
      check($sformatf("table %0d button_clean", i), 32'(bus.button_clean), 32'(vecs[i].exp_b));
      check($sformatf("table %0d switch_clean", i), 32'(bus.switch_clean), 32'(vecs[i].exp_s));
    end

    // 2: press key 0.
    bus.button_raw = 4'hE;
    measure("t2 press key0", 10, 1'b0, 10, {4'b0001, 10'h000});

    // 3: key 2 bounces every 3 cycles for 30 cycles, then holds pressed.
    for (int ph = 0; ph < 10; ph++) begin
      bus.button_raw[2] = ph[0];
      repeat (3) begin
        tick();
        cur = cur_clean();
        check("t3 bounce key2 clean", 32'(cur[12]), 32'h1);
        check("t3 bounce pulse", 32'(cur_pulse()), 32'h0);
      end
    end
    bus.button_raw[2] = 1'b0;
    measure("t3 hold key2", 12, 1'b0, 10, {4'b0100, 10'h000});

    // 4: all switches flip at once.
    bus.switch_raw = 10'h3FF;
    measure("t4 switches", 0, 1'b1, 10, {4'b0000, 10'h3FF});
    check("t4 switch_clean", 32'(bus.switch_clean), 32'h3FF);

    // 5: release key 0, no strobe expected.
    bus.button_raw[0] = 1'b1;
    measure("t5 release key0", 10, 1'b1, 10, 14'h0);

    // 6: reset 5 cycles into qualification; latency counts from release.
    settle(4'hF, 10'h000);
    bus.button_raw = 4'hD;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    measure("t6 after reset key1", 11, 1'b0, 10, {4'b0010, 10'h000});

    // Randomised activity against the reference model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        int unsigned b;
        b = $urandom_range(0, 13);
        if (b >= 10) bus.button_raw[b-10] = ~bus.button_raw[b-10];
        else bus.switch_raw[b] = ~bus.switch_raw[b];
      end
      tick();
    end
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
